// File: rtl/writeback_regfile.sv
// Writeback stage and 16 x DATA_WIDTH architectural register file.
// Selects the writeback source from the opcode, commits it, serves two bypassed read ports, and tracks retire/halt.
module writeback_regfile #(
    parameter int DATA_WIDTH  = 20,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wb_valid,
    input  logic [19:0]            wb_instruction,
    input  logic [DATA_WIDTH-1:0]  wb_alu_result,
    input  logic [DATA_WIDTH-1:0]  wb_mem_data,
    input  logic [3:0]             rd_addr1,
    input  logic [3:0]             rd_addr2,
    output logic [DATA_WIDTH-1:0]  rd_data1,
    output logic [DATA_WIDTH-1:0]  rd_data2,
    output logic                   wb_write_en,
    output logic [3:0]             wb_write_addr,
    output logic [DATA_WIDTH-1:0]  wb_write_data,
    output logic [COUNT_WIDTH-1:0] retired_count,
    output logic                   halted
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_SUB  = 4'b0010,
        OP_AND  = 4'b0011,
        OP_OR   = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_ADDI = 4'b0110,
        OP_LW   = 4'b0111,
        OP_SW   = 4'b1000,
        OP_BEQ  = 4'b1001,
        OP_J    = 4'b1010,
        OP_LI   = 4'b1011,
        OP_HALT = 4'b1111
    } opcode_e;

    logic [DATA_WIDTH-1:0] regs [16];
    opcode_e               opcode;
    logic                  writes_reg;
    logic                  retire;

    // Bubbles may carry X from the un-reset MEM/WB register, so the decode only sees a valid slot.
    always_comb begin
        opcode        = OP_NOP;
        wb_write_addr = '0;
        writes_reg    = 1'b0;
        wb_write_data = '0;
        if (wb_valid) begin
            opcode        = opcode_e'(wb_instruction[19:16]);
            wb_write_addr = wb_instruction[15:12];
            case (opcode)
                OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_ADDI, OP_LI: begin
                    writes_reg    = 1'b1;
                    wb_write_data = wb_alu_result;
                end
                OP_LW: begin
                    writes_reg    = 1'b1;
                    wb_write_data = wb_mem_data;
                end
                default: begin
                    writes_reg    = 1'b0;
                    wb_write_data = wb_alu_result;
                end
            endcase
        end
    end

    assign retire      = wb_valid && !halted;
    assign wb_write_en = retire && !reset && writes_reg && (wb_write_addr != 4'd0);

    always_comb begin
        rd_data1 = regs[rd_addr1];
        if (rd_addr1 == 4'd0)
            rd_data1 = '0;
        else if (wb_write_en && wb_write_addr == rd_addr1)
            rd_data1 = wb_write_data;
    end

    always_comb begin
        rd_data2 = regs[rd_addr2];
        if (rd_addr2 == 4'd0)
            rd_data2 = '0;
        else if (wb_write_en && wb_write_addr == rd_addr2)
            rd_data2 = wb_write_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the array is cleared explicitly because reset must zero architectural state; this rules out a RAM macro.
            for (int i = 0; i < 16; i++)
                regs[i] <= '0;
            retired_count <= '0;
            halted        <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every read in this block sees pre-edge state.
            if (wb_write_en)
                regs[wb_write_addr] <= wb_write_data;
            if (retire) begin
                if (retired_count != '1)
                    retired_count <= retired_count + 1'b1;
                if (opcode == OP_HALT)
                    halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_writeback_regfile.sv
// Randomized self-checking bench for writeback_regfile against an array/integer reference model.
// A second instance with a 4-bit counter exercises counter saturation in a short run.
module tb_writeback_regfile;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid;
    logic [19:0] wb_instruction;
    logic [19:0] wb_alu_result;
    logic [19:0] wb_mem_data;
    logic [3:0]  rd_addr1, rd_addr2;
    logic [19:0] rd_data1, rd_data2, wb_write_data;
    logic        wb_write_en, halted;
    logic [3:0]  wb_write_addr;
    logic [15:0] retired_count;

    logic [19:0] s_rd_data1, s_rd_data2, s_wb_write_data;
    logic        s_wb_write_en, s_halted;
    logic [3:0]  s_wb_write_addr;
    logic [3:0]  s_retired_count;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state
    logic [19:0] m_regs [16];
    int          m_count;
    int          m_count_small;
    bit          m_halted;

    always #5 clock = ~clock;

    writeback_regfile dut (
        .clock(clock), .reset(reset), .wb_valid(wb_valid),
        .wb_instruction(wb_instruction), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_write_en(wb_write_en), .wb_write_addr(wb_write_addr), .wb_write_data(wb_write_data),
        .retired_count(retired_count), .halted(halted)
    );

    writeback_regfile #(.DATA_WIDTH(20), .COUNT_WIDTH(4)) dut_small (
        .clock(clock), .reset(reset), .wb_valid(wb_valid),
        .wb_instruction(wb_instruction), .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(s_rd_data1), .rd_data2(s_rd_data2),
        .wb_write_en(s_wb_write_en), .wb_write_addr(s_wb_write_addr), .wb_write_data(s_wb_write_data),
        .retired_count(s_retired_count), .halted(s_halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_writes(input logic [3:0] op);
        return (op >= 4'd1 && op <= 4'd7) || op == 4'd11;
    endfunction

    function automatic logic [19:0] m_src(input logic [3:0] op);
        return (op == 4'd7) ? wb_mem_data : wb_alu_result;
    endfunction

    function automatic bit m_en();
        if (!wb_valid || m_halted || reset) return 0;
        return m_writes(wb_instruction[19:16]) && wb_instruction[15:12] != 4'd0;
    endfunction

    function automatic logic [19:0] m_read(input logic [3:0] a);
        if (a == 4'd0) return 20'd0;
        if (m_en() && wb_instruction[15:12] == a) return m_src(wb_instruction[19:16]);
        return m_regs[a];
    endfunction

    // One cycle: inputs are already driven; check combinational and state outputs, then advance the model at the edge.
    task automatic step(input bit full_check);
        bit          en;
        logic [3:0]  op, rd;
        #1;
        en = m_en();
        op = wb_instruction[19:16];
        rd = wb_instruction[15:12];
        if (full_check) begin
            check("write_en", {31'd0, wb_write_en}, {31'd0, en});
            if (en) begin
                check("write_addr", {28'd0, wb_write_addr}, {28'd0, rd});
                check("write_data", {12'd0, wb_write_data}, {12'd0, m_src(op)});
            end
            check("rd_data1", {12'd0, rd_data1}, {12'd0, m_read(rd_addr1)});
            check("rd_data2", {12'd0, rd_data2}, {12'd0, m_read(rd_addr2)});
            check("retired_count", {16'd0, retired_count}, m_count);
            check("retired_count_small", {28'd0, s_retired_count}, m_count_small);
            check("halted", {31'd0, halted}, {31'd0, m_halted});
        end
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 20'd0;
            m_count       = 0;
            m_count_small = 0;
            m_halted      = 0;
        end else begin
            if (en) m_regs[rd] = m_src(op);
            if (wb_valid && !m_halted) begin
                if (m_count < 16'hFFFF) m_count++;
                if (m_count_small < 15) m_count_small++;
                if (op == 4'hF) m_halted = 1;
            end
        end
        @(negedge clock);
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [3:0] rd,
                         input logic [19:0] alu, input logic [19:0] mem,
                         input logic [3:0] a1, input logic [3:0] a2, input bit rst);
        wb_valid       = v;
        wb_instruction = {op, rd, 12'($urandom)};
        wb_alu_result  = alu;
        wb_mem_data    = mem;
        rd_addr1       = a1;
        rd_addr2       = a2;
        reset          = rst;
        step(1);
    endtask

    initial begin
        reset = 1'b1; wb_valid = 1'b0; wb_instruction = '0;
        wb_alu_result = '0; wb_mem_data = '0; rd_addr1 = '0; rd_addr2 = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = 20'd0;
        m_count = 0; m_count_small = 0; m_halted = 0;
        @(negedge clock);
        step(0);
        drive(0, 4'h0, 4'h0, 20'h0, 20'h0, 4'd3, 4'd5, 1);

        // ADD to R3 with same-cycle bypass, then array read
        drive(1, 4'h1, 4'd3, 20'h12345, 20'h0, 4'd3, 4'd3, 0);
        drive(0, 4'h0, 4'd0, 20'h0, 20'h0, 4'd3, 4'd0, 0);

        // LW to R5 uses memory data; SW/BEQ/NOP to R5 leave it alone but retire
        drive(1, 4'h7, 4'd5, 20'h11111, 20'hABCDE, 4'd5, 4'd3, 0);
        drive(1, 4'h8, 4'd5, 20'h22222, 20'h33333, 4'd5, 4'd5, 0);
        drive(1, 4'h9, 4'd5, 20'h44444, 20'h55555, 4'd5, 4'd3, 0);
        drive(1, 4'h0, 4'd5, 20'h66666, 20'h77777, 4'd5, 4'd5, 0);
        drive(1, 4'hB, 4'd9, 20'h0BEEF, 20'h0, 4'd9, 4'd5, 0);

        // Write to R0 is dropped but still retires
        drive(1, 4'h6, 4'd0, 20'hFFFFF, 20'h0, 4'd0, 4'd0, 0);

        // Bubbles carrying X must not disturb state
        for (int i = 0; i < 10; i++) begin
            wb_valid = 1'b0; wb_instruction = 'x; wb_alu_result = 'x; wb_mem_data = 'x;
            rd_addr1 = 4'(i); rd_addr2 = 4'(15 - i); reset = 1'b0;
            step(1);
            check("no_x", {31'd0, $isunknown({rd_data1, rd_data2, wb_write_en, retired_count, halted})}, 32'd0);
        end

        // HALT freezes writes and counting until reset
        drive(1, 4'hF, 4'd0, 20'h0, 20'h0, 4'd3, 4'd5, 0);
        drive(1, 4'h1, 4'd2, 20'h0AAAA, 20'h0, 4'd2, 4'd2, 0);
        drive(1, 4'h1, 4'd2, 20'h0AAAA, 20'h0, 4'd2, 4'd3, 0);
        drive(0, 4'h0, 4'd0, 20'h0, 20'h0, 4'd3, 4'd5, 1);
        drive(0, 4'h0, 4'd0, 20'h0, 20'h0, 4'd3, 4'd5, 0);

        // Saturation of the narrow counter, then reset beating a simultaneous write to R7
        for (int i = 0; i < 20; i++)
            drive(1, 4'h0, 4'($urandom), 20'($urandom), 20'($urandom), 4'($urandom), 4'($urandom), 0);
        drive(1, 4'h1, 4'd7, 20'h77777, 20'h0, 4'd7, 4'd7, 1);
        drive(0, 4'h0, 4'd0, 20'h0, 20'h0, 4'd7, 4'd7, 0);

        // Randomized traffic; addresses often alias the WB destination to stress the bypass
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] rd;
            rd = 4'($urandom);
            drive($urandom_range(0, 9) != 0,
                  4'($urandom), rd, 20'($urandom), 20'($urandom),
                  $urandom_range(0, 1) ? rd : 4'($urandom),
                  $urandom_range(0, 2) == 0 ? rd : 4'($urandom),
                  $urandom_range(0, 39) == 0 || (m_halted && $urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
